// File: rtl/if_id_stage.sv
// Fetch stage with the IF/ID pipeline register, PC, redirect handling and fetched-instruction counter.
// Latency: one cycle from imem_addr to id_instr; redirects insert exactly one bubble.
// Backpressure: stall holds the PC and IF/ID register; a redirect overrides stall, flush only clears IF/ID.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic        redirect;

  logic [31:0] id_instr_next;
  logic [31:0] id_pc_plus4_next;
  logic        id_valid_next;
  logic [31:0] fetch_count_next;

  // Address arithmetic: sequential PC wraps naturally at 2^32; jump stays in the 256MB region of the decoded instruction
  always_comb begin
    pc_plus4        = pc + 32'd4;
    jump_target     = {id_pc_plus4[31:28], jump_index, 2'b00};
    redirect        = jump | branch_taken;
    redirect_target = jump ? jump_target : branch_target;
  end

  // Next-state and datapath selection; priority is redirect > flush > stall > sequential fetch
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    id_instr_next    = id_instr;
    id_pc_plus4_next = id_pc_plus4;
    id_valid_next    = id_valid;
    fetch_count_next = fetch_count;
    case (state)
      BOOT: begin
        // First cycle out of reset: nothing is fetched and redirects are ignored
        state_next = RUN;
      end
      RUN, HOLD: begin
        if (redirect) begin
          pc_next       = redirect_target;
          id_instr_next = 32'h00000000;
          id_valid_next = 1'b0;
          state_next    = RUN;
        end else if (flush) begin
          id_instr_next = 32'h00000000;
          id_valid_next = 1'b0;
          if (!stall) begin
            pc_next = pc_plus4;
          end
          state_next = stall ? HOLD : RUN;
        end else if (stall) begin
          state_next = HOLD;
        end else begin
          id_instr_next    = imem_rdata;
          id_pc_plus4_next = pc_plus4;
          id_valid_next    = 1'b1;
          fetch_count_next = fetch_count + 32'd1;
          pc_next          = pc_plus4;
          state_next       = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // State, PC and IF/ID register; reset takes effect immediately and discards any pending operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      id_instr    <= 32'h00000000;
      id_pc_plus4 <= 32'h00000000;
      id_valid    <= 1'b0;
      fetch_count <= 32'h00000000;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      id_instr    <= id_instr_next;
      id_pc_plus4 <= id_pc_plus4_next;
      id_valid    <= id_valid_next;
      fetch_count <= fetch_count_next;
    end
  end

  // Fetch address is the PC itself; opcode is taken straight from the registered word so bubbles decode as 0
  always_comb begin
    imem_addr = pc;
    id_opcode = id_instr[31:26];
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a cycle-level reference model and literal spot checks.
// Latency: model updates on each rising edge; outputs compared on falling edges.
// Backpressure: stall, flush and redirects driven directly from the stimulus sequence.
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  if_id_stage #(.RESET_PC(32'h00000000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .imem_rdata   (imem_rdata),
    .imem_addr    (imem_addr),
    .id_instr     (id_instr),
    .id_opcode    (id_opcode),
    .id_pc_plus4  (id_pc_plus4),
    .id_valid     (id_valid),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word k holds 32'h20080000 + k
  function automatic logic [31:0] memword(input logic [31:0] addr);
    return 32'h20080000 + {2'b00, addr[31:2]};
  endfunction

  assign imem_rdata = memword(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pipeline described as "what the fetch unit has done so far"
  logic [31:0] m_pc, m_instr, m_pp4, m_count;
  logic        m_valid, m_boot;

  always @(posedge clk or posedge rst) begin
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_count = 32'h0;
      m_valid = 1'b0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (jump || branch_taken) begin
      tgt = jump ? {m_pp4[31:28], jump_index, 2'b00} : branch_target;
      m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
    end else if (flush) begin
      m_instr = 32'h0; m_valid = 1'b0;
      if (!stall) m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_instr = memword(m_pc);
      m_pp4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
  end

  bit started = 1'b0;

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("m_addr",   imem_addr,   m_pc);
      chk("m_instr",  id_instr,    m_instr);
      chk("m_opcode", {26'd0, id_opcode}, {26'd0, m_instr[31:26]});
      chk("m_pp4",    id_pc_plus4, m_pp4);
      chk("m_valid",  {31'd0, id_valid}, {31'd0, m_valid});
      chk("m_count",  fetch_count, m_count);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 32'h0; jump_index = 26'h0;
  endtask

  logic [31:0] cnt_before;

  initial begin
    rst = 1'b1;
    idle();
    #12;
    chk("rst_addr",  imem_addr,   32'h0);
    chk("rst_instr", id_instr,    32'h0);
    chk("rst_valid", {31'd0, id_valid}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    #10 rst = 1'b0;
    started = 1'b1;
    chk("boot_addr0", imem_addr, 32'h0);
    tick();                                   // BOOT edge
    chk("boot_addr1", imem_addr, 32'h0);
    chk("boot_valid", {31'd0, id_valid}, 32'h0);
    tick();                                   // first fetch
    chk("first_addr",  imem_addr, 32'h4);
    chk("first_instr", id_instr,  32'h20080000);
    chk("first_valid", {31'd0, id_valid}, 32'h1);
    tick();
    chk("addr8", imem_addr, 32'h8);

    // Stall for three cycles at PC=8
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr",  imem_addr,   32'h8);
      chk("stall_instr", id_instr,    32'h20080001);
      chk("stall_count", fetch_count, 32'd2);
    end
    stall = 0;
    tick();
    chk("resume_instr", id_instr, 32'h20080002);
    chk("resume_addr",  imem_addr, 32'hC);
    tick();
    chk("resume_instr2", id_instr, 32'h20080003);

    // Branch together with stall: redirect wins
    stall = 1; branch_taken = 1; branch_target = 32'h40;
    tick();
    chk("br_addr",  imem_addr, 32'h40);
    chk("br_valid", {31'd0, id_valid}, 32'h0);
    chk("br_instr", id_instr, 32'h0);
    idle();
    tick();
    chk("br_fetch",  id_instr, 32'h20080010);
    chk("br_fvalid", {31'd0, id_valid}, 32'h1);

    // Flush alone advances PC; flush with stall holds PC
    flush = 1;
    tick();
    chk("fl_addr",  imem_addr, 32'h48);
    chk("fl_valid", {31'd0, id_valid}, 32'h0);
    stall = 1;
    tick();
    chk("flst_addr", imem_addr, 32'h48);
    idle();
    tick();
    tick();

    // Jump beats branch; jump region from id_pc_plus4
    branch_taken = 1; branch_target = 32'h10000004;
    tick();
    idle();
    tick();
    chk("j_pp4", id_pc_plus4, 32'h10000008);
    jump = 1; jump_index = 26'h10; branch_taken = 1; branch_target = 32'h80;
    tick();
    chk("j_addr",  imem_addr, 32'h10000040);
    chk("j_valid", {31'd0, id_valid}, 32'h0);
    idle();
    tick();

    // PC wrap at the top of the address space
    branch_taken = 1; branch_target = 32'hFFFFFFF8;
    tick();
    idle();
    tick();
    chk("wrap_pre", imem_addr, 32'hFFFFFFFC);
    cnt_before = fetch_count;
    tick();
    chk("wrap_addr",  imem_addr,   32'h0);
    chk("wrap_pp4",   id_pc_plus4, 32'h0);
    chk("wrap_instr", id_instr,    32'h6007FFFF);
    chk("wrap_count", fetch_count, cnt_before + 32'd1);
    tick();

    // Asynchronous reset pulse mid-stall, then redirect ignored during BOOT
    stall = 1;
    tick();
    #3 rst = 1'b1;
    #1;
    chk("arst_addr",  imem_addr,   32'h0);
    chk("arst_instr", id_instr,    32'h0);
    chk("arst_pp4",   id_pc_plus4, 32'h0);
    chk("arst_valid", {31'd0, id_valid}, 32'h0);
    chk("arst_count", fetch_count, 32'h0);
    #2 rst = 1'b0;
    idle();
    branch_taken = 1; branch_target = 32'h40;
    tick();                                   // BOOT edge ignores the branch
    chk("boot2_addr",  imem_addr, 32'h0);
    chk("boot2_valid", {31'd0, id_valid}, 32'h0);
    idle();
    tick();
    chk("boot2_fetch", id_instr, 32'h20080000);
    chk("boot2_count", fetch_count, 32'd1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
